// File: rtl/tty_uart_tx_if.sv
// Memory-interface side of the TTY console: write strobe, AHB ready and the byte to print.
interface tty_uart_tx_if;
    logic       HREADY;
    logic       tty_enable;
    logic [7:0] tty_data;

    modport master (output HREADY, output tty_enable, output tty_data);
    modport slave  (input  HREADY, input  tty_enable, input  tty_data);
endinterface

// File: rtl/tty_uart_tx.sv
// TTY console back-end: buffers bytes written by the CPU and sends them as 8N1 UART frames, LSB first.
// Handshake: a byte is offered on every HCLK edge where tty_enable & HREADY; it is accepted unless the FIFO is full and not popping.
module tty_uart_tx #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BAUD_DIV        = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    tty_uart_tx_if.slave             bus,
    output logic                     uart_txd,
    output logic                     tx_busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     char_sent,
    output logic                     eol_pulse,
    output logic [1:0]               tx_state
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = $clog2(BAUD_DIV);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_V  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [BW-1:0]            BAUD_MAX = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       fifo_empty;
    logic                       push_req;
    logic                       push;
    logic                       pop;

    state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] tx_byte, byte_n;
    logic       txd_q, txd_n;
    logic       baud_last;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_V);
    assign push_req   = bus.tty_enable & bus.HREADY;
    // A same-edge pop frees the slot, so a write to a full FIFO still lands.
    assign push       = push_req & (~fifo_full | pop);

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.tty_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    assign baud_last = (baud_cnt == BAUD_MAX);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            tx_byte  <= byte_n;
            txd_q    <= txd_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        byte_n  = tx_byte;
        txd_n   = txd_q;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                txd_n  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    byte_n  = mem[rd_ptr];
                    txd_n   = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    txd_n   = tx_byte[0];
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        txd_n = tx_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    // Back-to-back: next start bit follows the stop bit with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        byte_n  = mem[rd_ptr];
                        txd_n   = 1'b0;
                        state_n = S_START;
                    end else begin
                        txd_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = (state != S_IDLE);
    assign fifo_count = count;
    assign char_sent  = (state == S_STOP) && baud_last;
    assign eol_pulse  = char_sent && (tx_byte == 8'h0D);
    assign tx_state   = state;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Bench for tty_uart_tx: random and directed writes, a frame-level reference model, and a serial-line monitor.
module tb_tty_uart_tx;
  localparam int L     = 2;
  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * D;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       uart_txd, tx_busy, fifo_full, overflow, char_sent, eol_pulse;
  logic [L:0] fifo_count;
  logic [1:0] tx_state;

  tty_uart_tx_if bus ();

  tty_uart_tx #(.FIFO_DEPTH_LOG2(L), .BAUD_DIV(D)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (bus),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .char_sent  (char_sent),
    .eol_pulse  (eol_pulse),
    .tx_state   (tx_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // scoreboard: bytes expected on the serial line, in order
  logic [7:0] exp_q[$];

  // reference model: buffered bytes, cycles left in the current frame, byte on the line
  logic [7:0] m_fifo[$];
  int         m_timer = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_cur = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    exp_q.delete();
    m_timer = 0;
    m_ovf   = 1'b0;
  endtask

  // one HCLK cycle of stimulus, model update on the same edge, then output checks
  task automatic cycle(input logic en, input logic rdy, input logic [7:0] d);
    bit         pop, acc;
    int         p;
    logic [9:0] fr;
    logic       exp_txd;
    bus.tty_enable = en;
    bus.HREADY     = rdy;
    bus.tty_data   = d;
    @(posedge HCLK);
    pop = (m_fifo.size() > 0) && (m_timer <= 1);
    acc = en && rdy && ((m_fifo.size() < DEPTH) || pop);
    if (en && rdy && !acc) m_ovf = 1'b1;
    if (pop) begin
      m_cur   = m_fifo.pop_front();
      m_timer = FRAME;
    end else if (m_timer > 0) begin
      m_timer--;
    end
    if (acc) begin
      m_fifo.push_back(d);
      exp_q.push_back(d);
    end
    if (m_timer == 0) begin
      exp_txd = 1'b1;
    end else begin
      p       = FRAME - m_timer;
      fr      = {1'b1, m_cur, 1'b0};
      exp_txd = fr[p / D];
    end
    #1;
    check("fifo_count", 32'(fifo_count), m_fifo.size());
    check("fifo_full", 32'(fifo_full), 32'(m_fifo.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_busy", 32'(tx_busy), 32'(m_timer != 0));
    check("uart_txd", 32'(uart_txd), 32'(exp_txd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 8'h00);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must drop to reset values at once
  task automatic do_reset(input int hold);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_char_sent", 32'(char_sent), 32'd0);
    model_clear();
    bus.tty_enable = 1'b0;
    bus.HREADY     = 1'b1;
    bus.tty_data   = 8'h00;
    repeat (hold) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  // monitor: decodes frames from uart_txd and checks them against exp_q and the stop-bit pulses
  initial begin
    logic       prev;
    logic [7:0] rx;
    logic       stop_v, cs_v, eo_v;
    bit         aborted;
    int         b;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge HCLK);
      if (HRESETn && uart_txd === 1'b0 && prev === 1'b1) begin
        aborted = 0;
        rx = 8'h00;
        stop_v = 1'b0;
        cs_v = 1'b0;
        eo_v = 1'b0;
        for (int j = 1; j <= FRAME; j++) begin
          if (j > 1) @(negedge HCLK);
          if (!HRESETn) begin
            aborted = 1;
            break;
          end
          if (j % D == 2) begin
            b = (j - 1) / D;
            if (b >= 1 && b <= 8) rx[b-1] = uart_txd;
            if (b == 9) stop_v = uart_txd;
          end
          if (j < FRAME && (char_sent !== 1'b0 || eol_pulse !== 1'b0)) begin
            checks++;
            errors++;
            $display("FAIL early_pulse: char_sent=%b eol_pulse=%b at frame cycle %0d, required 0", char_sent, eol_pulse, j);
          end
          if (j == FRAME) begin
            cs_v = char_sent;
            eo_v = eol_pulse;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h, required no frame", rx);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(rx), 32'(e));
            check("stop_bit", 32'(stop_v), 32'd1);
            check("char_sent_end", 32'(cs_v), 32'd1);
            check("eol_pulse_end", 32'(eo_v), 32'(e == 8'h0D));
          end
        end
        prev = 1'b1;
      end else begin
        if (HRESETn && (char_sent === 1'b1 || eol_pulse === 1'b1)) begin
          checks++;
          errors++;
          $display("FAIL stray_pulse: char_sent=%b eol_pulse=%b outside a frame, required 0", char_sent, eol_pulse);
        end
        prev = uart_txd;
      end
    end
  end

  initial begin
    int n;
    bus.tty_enable = 1'b0;
    bus.HREADY     = 1'b1;
    bus.tty_data   = 8'h00;
    HRESETn        = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    check("init_txd", 32'(uart_txd), 32'd1);
    check("init_busy", 32'(tx_busy), 32'd0);
    check("init_count", 32'(fifo_count), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    check("init_full", 32'(fifo_full), 32'd0);
    idle(50);

    // HREADY low gates the write completely
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hFF);
    idle(5);

    // single byte, then carriage return
    cycle(1'b1, 1'b1, 8'h41);
    idle(50);
    cycle(1'b1, 1'b1, 8'h0D);
    idle(50);

    // six consecutive writes: one pop overlaps, FIFO fills, last byte dropped
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i));
    idle(220);

    // reset during data bit 3 of the first of two queued bytes
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b1, 1'b1, 8'hAA);
    idle(17);
    do_reset(3);
    idle(100);

    // random traffic with random HREADY stalls
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
    end

    // drain with a bounded wait
    n = 0;
    while ((m_timer != 0 || m_fifo.size() != 0) && n < 1000) begin
      idle(1);
      n++;
    end
    check("drain_done", 32'(m_timer != 0 || m_fifo.size() != 0), 32'd0);
    idle(5);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tty_uart_tx.md
# tty_uart_tx

Console back-end for the testbench memory interface. It captures each byte the CPU writes to the TTY address (0x40000000) and buffers it in a small FIFO. It then serialises the bytes onto a single UART TX line (8N1, LSB first) at a fixed clock-divided bit rate. It sits directly downstream of the memory interface's `tty_enable` / `hwdata_out` outputs, so bench software sees the console stream as real serial frames.

## Interface
Parameters:
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2**FIFO_DEPTH_LOG2 bytes; minimum 1.
- `BAUD_DIV`, default 16: HCLK cycles per serial bit; minimum 2.

Ports:
- `HCLK`  in  1  single clock; all state updates on posedge.
- `HRESETn`  in  1  reset, asynchronous assert, active-low.
- `HREADY`  in  1  AHB ready; a TTY write commits only when high.
- `tty_enable`  in  1  TTY write data phase active, from the memory interface.
- `tty_data`  in  8  byte to print (HWDATA[7:0]).
- `uart_txd`  out  1  serial output, registered; idle high.
- `tx_busy`  out  1  high while a frame is in START/DATA/STOP.
- `fifo_count`  out  FIFO_DEPTH_LOG2+1  bytes currently buffered.
- `fifo_full`  out  1  `fifo_count` == 2**FIFO_DEPTH_LOG2.
- `overflow`  out  1  sticky; a write was dropped because the FIFO was full.
- `char_sent`  out  1  one-cycle pulse in the last cycle of a stop bit.
- `eol_pulse`  out  1  one-cycle pulse coincident with `char_sent` when the sent byte was 8'h0D.

## Operation
- Push occurs on a posedge where `tty_enable & HREADY` is high.
- If the FIFO is not full, `tty_data` is written at the write pointer.
- If the FIFO is full, the byte is dropped and `overflow` is set to 1. `overflow` is cleared only by reset.
- Pointers are FIFO_DEPTH_LOG2 bits wide and wrap modulo depth. The count is a separate register.
- Simultaneous push and pop:
  - The count is unchanged.
  - When the FIFO is full, the same-edge pop frees the slot, so the push is accepted and `overflow` is not set.
- TX FSM states are IDLE, START, DATA, STOP. A baud counter counts 0..BAUD_DIV-1 and a 3-bit index tracks the data bit.
- IDLE:
  - When the FIFO is non-empty, pop into an 8-bit shift register and go to START.
  - Set `uart_txd`=0 and clear the baud counter.
- START: after BAUD_DIV cycles, go to DATA with bit index 0 and drive `uart_txd`=shift[0].
- DATA: each BAUD_DIV cycles, advance to the next bit, LSB first. After bit 7 completes, go to STOP with `uart_txd`=1.
- STOP: in the last cycle (baud counter = BAUD_DIV-1), pulse `char_sent`, and pulse `eol_pulse` if the byte was 8'h0D. Then:
  - If the FIFO is non-empty, pop and go directly to START with `uart_txd`=0 (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- `tx_busy` = (state != IDLE).

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0, `char_sent`=0, `eol_pulse`=0; FSM in IDLE, pointers at 0.
- Latency:
  - A write accepted at edge k makes `fifo_count` 1 after edge k.
  - The IDLE pop occurs at edge k+1, where `uart_txd` falls and `fifo_count` returns to 0.
- Frame length is exactly 10*BAUD_DIV cycles measured from the falling edge of `uart_txd`. Back-to-back frames repeat with period 10*BAUD_DIV.
- Reset mid-frame: all outputs immediately take their reset values (`uart_txd`=1 asynchronously), FIFO contents are discarded, and no `char_sent` is generated.
- `tty_enable` high with `HREADY` low has no effect in that cycle.

## Test plan
(Test plan uses BAUD_DIV=4, FIFO_DEPTH_LOG2=2.)
- Reset check: assert `HRESETn`=0 for 3 cycles, release → `uart_txd`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0, no pulses for 50 cycles.
- Single byte: write 8'h41 at edge k → `uart_txd` low from edge k+1 for 4 cycles. Data bits then read 1,0,0,0,0,0,1,0 at 4 cycles each, followed by stop high for 4 cycles. `char_sent` pulses at cycle 40 of the frame; `eol_pulse` stays 0.
- Overflow with simultaneous push/pop: write 6 bytes 8'h30..8'h35 on consecutive edges k..k+5:
  - Edge k+1 pops 8'h30 while pushing 8'h31, leaving `fifo_count`=1.
  - Count reaches 4 (`fifo_full`=1) at edge k+4; 8'h35 is dropped and `overflow`=1.
  - 8'h30..8'h34 go out back-to-back in 200 cycles, with 5 `char_sent` pulses exactly 40 cycles apart.
- EOL: write 8'h0D → after one frame, `eol_pulse` and `char_sent` both pulse in the same cycle, once.
- HREADY gating: `tty_enable`=1 with `HREADY`=0 for 5 cycles, data 8'hFF → `fifo_count` stays 0 and `uart_txd` stays 1.
- Reset mid-frame: queue 8'h55 and 8'hAA, then assert reset during the DATA bit 3 of 8'h55 → `uart_txd`=1 immediately and `fifo_count`=0. After release, no further frames are sent and no `char_sent` occurs.
